// File: rtl/recorder_pkg.sv
// recorder_pkg: shared state encoding and defaults for the score recorder
package recorder_pkg;
  typedef enum logic [1:0] {IDLE, RECORD, WRITE, DONE} state_t;
  localparam int SONG_LEN_DEF = 128;
  localparam int HIST_W_DEF = 8;
  localparam logic [3:0] NOTE_REST = 4'd0;
endpackage

// File: rtl/note_histogram.sv
// note_histogram: 16 saturating per-note bins with lowest-index argmax
module note_histogram
  import recorder_pkg::*;
#(
  parameter int HIST_W = HIST_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  input  logic [3:0] note,
  output logic [3:0] winner
);
  localparam logic [HIST_W-1:0] MAX = '1;
  logic [HIST_W-1:0] r_bin [16];
  logic [HIST_W-1:0] w_next [16];
  logic [HIST_W-1:0] w_best;
  // next bin values include this cycle's sample so the winner covers a closing window's last sample
  always_comb begin
    w_best = '0;
    winner = NOTE_REST;
    for (int i = 0; i < 16; i++) begin
      w_next[i] = r_bin[i] + HIST_W'(inc && note == 4'(i) && r_bin[i] != MAX);
      if (w_next[i] > w_best) begin
        w_best = w_next[i];
        winner = 4'(i);
      end
    end
  end
  // clearing starts a new window that may already hold this cycle's sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) for (int i = 0; i < 16; i++) r_bin[i] <= '0;
    else for (int i = 0; i < 16; i++) r_bin[i] <= clear ? HIST_W'(inc && note == 4'(i)) : w_next[i];
  end
endmodule

// File: rtl/score_recorder.sv
// score_recorder: records the dominant detected note per beat and scores it against the score
module score_recorder
  import recorder_pkg::*;
#(
  parameter int SONG_LEN = SONG_LEN_DEF,
  parameter int HIST_W = HIST_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       beat,
  input  logic [3:0] expected_note,
  input  logic [3:0] note_in,
  input  logic       note_valid,
  output logic       wr_en,
  output logic [6:0] wr_addr,
  output logic [3:0] wr_data,
  output logic [7:0] hits,
  output logic [7:0] misses,
  output logic       last_hit,
  output logic       busy,
  output logic       done
);
  state_t r_state;
  logic r_wr_en, r_last_hit, r_stop_end;
  logic [6:0] r_wr_addr;
  logic [3:0] r_wr_data;
  logic [7:0] r_hits, r_misses;
  logic [3:0] w_winner;
  logic w_go, w_clear, w_inc, w_hit;
  assign w_go = start && (r_state == IDLE || r_state == DONE);
  assign w_clear = w_go || r_state == WRITE;
  assign w_inc = note_valid && (r_state == RECORD || r_state == WRITE);
  assign w_hit = w_winner == expected_note;
  note_histogram #(.HIST_W(HIST_W)) u_hist (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .inc   (w_inc),
    .note  (note_in),
    .winner(w_winner)
  );
  // take sequencing; the write and its score update land together one cycle after beat/stop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_wr_en <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= NOTE_REST;
      r_hits <= '0;
      r_misses <= '0;
      r_last_hit <= 1'b0;
      r_stop_end <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_go) begin
        r_state <= RECORD;
        r_wr_addr <= '0;
        r_hits <= '0;
        r_misses <= '0;
        r_last_hit <= 1'b0;
      end else if (r_state == RECORD && (beat || stop)) begin
        r_state <= WRITE;
        r_wr_en <= 1'b1;
        r_wr_data <= w_winner;
        r_stop_end <= stop;
        r_last_hit <= w_hit;
        r_hits <= r_hits + 8'(w_hit && r_hits != 8'hFF);
        r_misses <= r_misses + 8'(!w_hit && r_misses != 8'hFF);
      end else if (r_state == WRITE) begin
        if (r_stop_end || r_wr_addr == 7'(SONG_LEN - 1)) r_state <= DONE;
        else begin
          r_state <= RECORD;
          r_wr_addr <= r_wr_addr + 7'd1;
        end
      end
    end
  end
  assign wr_en = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign hits = r_hits;
  assign misses = r_misses;
  assign last_hit = r_last_hit;
  assign busy = r_state == RECORD || r_state == WRITE;
  assign done = r_state == DONE;
endmodule

// File: doc/score_recorder.md
SCORE_RECORDER -- requirements
Module: score_recorder

Interface
REQ-001 SHALL have parameter SONG_LEN, default 128, number of beats (notes) recorded per take (1..128).
REQ-002 SHALL have parameter HIST_W, default 8, width of each per-note sample counter.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a take.
REQ-006 SHALL have port stop  input  1  one-cycle pulse that ends a take early.
REQ-007 SHALL have port beat  input  1  one-cycle tempo pulse from the score loader.
REQ-008 SHALL have port expected_note  input  4  note in loader window slot 0, sampled on the beat cycle.
REQ-009 SHALL have port note_in  input  4  note code from the pitch detector.
REQ-010 SHALL have port note_valid  input  1  qualifies note_in for this cycle.
REQ-011 SHALL have port wr_en  output  1  one-cycle write strobe to the take RAM.
REQ-012 SHALL have port wr_addr  output  7  take RAM address.
REQ-013 SHALL have port wr_data  output  4  recorded note.
REQ-014 SHALL have port hits  output  8  count of beats matching expected_note, saturating at 255.
REQ-015 SHALL have port misses  output  8  count of non-matching beats, saturating at 255.
REQ-016 SHALL have port last_hit  output  1  match result of the most recent write.
REQ-017 SHALL have port busy  output  1  high in RECORD and WRITE.
REQ-018 SHALL have port done  output  1  high in DONE.

Function
REQ-019 SHALL implement states IDLE, RECORD, WRITE, DONE.
REQ-020 SHALL move IDLE->RECORD and DONE->RECORD on start, clearing histogram, wr_addr, hits, misses and last_hit; start SHALL be ignored in RECORD and WRITE.
REQ-021 SHALL, in RECORD, add 1 to bin[note_in] on every cycle where note_valid=1, with each bin saturating at 2^HIST_W-1.
REQ-022 SHALL count a valid sample arriving on the beat cycle in the window that is closing.
REQ-023 SHALL, on beat or stop in RECORD, go to WRITE and latch expected_note and the histogram winner.
REQ-024 SHALL pick as winner the bin with the largest count, breaking ties toward the lowest index; if all bins are zero, the winner SHALL be 4'd0 (rest).
REQ-025 SHALL, in WRITE, drive wr_en=1 and wr_data=winner for exactly one cycle at the current wr_addr.
REQ-026 SHALL, in WRITE, increment hits if winner==expected_note (rest==rest counts as a hit), otherwise increment misses, and set last_hit accordingly.
REQ-027 SHALL, in WRITE, clear the histogram, then count any valid sample of that cycle into the new window.
REQ-028 SHALL leave WRITE in one cycle: to DONE if stop caused it or wr_addr==SONG_LEN-1, otherwise to RECORD with wr_addr+1.
REQ-029 SHALL ignore beat and stop in WRITE, IDLE and DONE; beats are required to be at least 2 cycles apart.
REQ-030 SHALL give stop priority when beat and stop coincide in RECORD; a single write occurs and the next state is DONE.
REQ-031 SHALL hold wr_addr at its final value in DONE.
REQ-032 SHALL have a latency of exactly 1 cycle from the beat/stop edge to the wr_en cycle.

Reset
REQ-033 SHALL, on reset, immediately set state=IDLE, wr_en=0, wr_addr=0, wr_data=0, hits=0, misses=0, last_hit=0, all bins=0, busy=0, done=0, including mid-take, with no write issued.

Structure
REQ-034 SHALL take the state encoding, NOTE_REST=4'd0, and the SONG_LEN/HIST_W defaults from a shared package recorder_pkg.
REQ-035 SHALL place the 16 saturating bins and the argmax logic in one sub-module, note_histogram (ports: clear, inc, note, winner).

Verification
REQ-036 SHALL verify: start, 10 cycles of note 5 valid, then beat with expected 5 -> one cycle later wr_en=1, wr_addr=0, wr_data=5, hits=1, last_hit=1.
REQ-037 SHALL verify: 4 samples of note 3 and 4 samples of note 7, then beat with expected 7 -> wr_data=3 (tie goes low), misses=1.
REQ-038 SHALL verify: no valid samples, beat with expected 0 -> wr_data=0, hit counted.
REQ-039 SHALL verify: SONG_LEN=4 with 4 beats -> writes to addresses 0..3, then done=1, and a 5th beat causes no wr_en.
REQ-040 SHALL verify: stop and beat in the same cycle at addr 2 -> a single write to address 2, then DONE; start afterwards -> counters cleared, wr_addr=0.
REQ-041 SHALL verify: reset asserted mid-RECORD between clock edges -> outputs cleared asynchronously, and the next beat does not write.
